// File: rtl/psram_target_pkg.sv
// psram_target_pkg
//   Shared types and constants for the octal-DDR PSRAM responder.
//   - state_t      : protocol state machine encoding
//   - *_CMD_DEF    : default read/write command codes
//   - CMD_EDGES    : SCK edges spent in the command phase (rise latches, fall decodes)
//   - ADDR_EDGES   : SCK edges carrying the 32-bit address, one byte per edge
package psram_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LAT,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] RD_CMD_DEF = 8'h00;
    localparam logic [7:0] WR_CMD_DEF = 8'h80;

    localparam logic [2:0] CMD_EDGES  = 3'd2;
    localparam logic [2:0] ADDR_EDGES = 3'd4;

endpackage

// File: rtl/psram_target_sampler.sv
// psram_target_sampler
//   Registers the PSRAM pins once into the clk domain and derives edge events.
//   Ports:
//     clk, rst   : local clock, synchronous active-high reset
//     sck, ce_n  : raw serial clock / chip enable (active low)
//     io, dqs    : raw DQ byte and DQS
//     io_q, dqs_q: registered DQ/DQS, aligned with the edge-event cycle
//     sck_rise   : registered SCK went 0->1 this cycle
//     sck_fall   : registered SCK went 1->0 this cycle
//     ce_high    : registered CE level (1 = deselected)
//     ce_fall    : registered CE went 1->0 this cycle (transaction start)
module psram_target_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [7:0] io,
    input  logic       dqs,
    output logic [7:0] io_q,
    output logic       dqs_q,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_high,
    output logic       ce_fall
);

    logic sck_q, sck_d;
    logic ce_q, ce_d;

    // CE history resets to "selected": a burst interrupted by reset must not
    // be re-entered mid-stream, so a new transaction needs a genuine CE
    // high->low transition after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= 1'b0;
            sck_d <= 1'b0;
            ce_q  <= 1'b0;
            ce_d  <= 1'b0;
            io_q  <= 8'h00;
            dqs_q <= 1'b0;
        end else begin
            sck_q <= sck;
            sck_d <= sck_q;
            ce_q  <= ce_n;
            ce_d  <= ce_q;
            io_q  <= io;
            dqs_q <= dqs;
        end
    end

    assign sck_rise = sck_q & ~sck_d;
    assign sck_fall = ~sck_q & sck_d;
    assign ce_high  = ce_q;
    assign ce_fall  = ~ce_q & ce_d;

endmodule

// File: rtl/psram_target.sv
// psram_target
//   Octal-DDR PSRAM device model / on-chip memory target. Decodes command,
//   32-bit address and latency, then streams bytes to/from a byte-wide memory.
//   Ports:
//     clk_i, rst_i           : clock (>= 4x SCK), synchronous active-high reset
//     cfg_rlc_i, cfg_wlc_i   : read / write latency in SCK cycles
//     psram_sck_i, psram_ce_i: serial clock, chip enable (active low)
//     psram_io_in_i/out_o/en_o   : DQ bus (en = 1 drives)
//     psram_dqs_in_i             : write byte enable (1 = write)
//     psram_dqs_out_o/en_o       : read strobe and its enable
//     mem_addr_o, mem_wr_en_o, mem_wr_data_o : byte write port
//     mem_rd_en_o, mem_rd_data_i             : byte read port, data one cycle after strobe
//     busy_o                 : transaction in progress
module psram_target
    import psram_target_pkg::*;
#(
    parameter int         MEM_AW = 16,
    parameter logic [7:0] RD_CMD = RD_CMD_DEF,
    parameter logic [7:0] WR_CMD = WR_CMD_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        cfg_rlc_i,
    input  logic [7:0]        cfg_wlc_i,
    input  logic              psram_sck_i,
    input  logic              psram_ce_i,
    input  logic [7:0]        psram_io_in_i,
    output logic [7:0]        psram_io_out_o,
    output logic [7:0]        psram_io_en_o,
    input  logic              psram_dqs_in_i,
    output logic              psram_dqs_out_o,
    output logic              psram_dqs_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_wr_en_o,
    output logic [7:0]        mem_wr_data_o,
    output logic              mem_rd_en_o,
    input  logic [7:0]        mem_rd_data_i,
    output logic              busy_o
);

    localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic [7:0] io_q;
    logic       dqs_q;
    logic       sck_rise, sck_fall;
    logic       ce_high, ce_fall;

    psram_target_sampler u_sampler (
        .clk      (clk_i),
        .rst      (rst_i),
        .sck      (psram_sck_i),
        .ce_n     (psram_ce_i),
        .io       (psram_io_in_i),
        .dqs      (psram_dqs_in_i),
        .io_q     (io_q),
        .dqs_q    (dqs_q),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ce_high  (ce_high),
        .ce_fall  (ce_fall)
    );

    state_t            state;
    logic [7:0]        cmd_q;
    logic [2:0]        edge_cnt;
    logic [31:0]       addr_sr;
    logic [7:0]        lat_cnt;
    logic              is_wr;
    logic [MEM_AW-1:0] ptr;
    logic [7:0]        prefetch;
    logic              rd_pend;

    logic              edge_evt;
    logic              data_edge;
    logic [31:0]       addr_full;
    logic [7:0]        next_byte;
    logic [MEM_AW-1:0] ptr_inc;

    assign edge_evt  = sck_rise | sck_fall;
    // Shift the whole register so the top byte falls off; MSB arrives first.
    assign addr_full = (addr_sr << 8) | {24'd0, io_q};
    assign ptr_inc   = ptr + PTR_ONE;

    // Data edge: any edge while streaming, or the first SCK rise seen in LAT
    // once the latency counter has run out (that rise is data edge 0).
    assign data_edge = ((state == ST_WDATA || state == ST_RDATA) && edge_evt) ||
                       ((state == ST_LAT) && sck_rise && (lat_cnt == 8'd0));

    // With SCK edges only two clocks apart the memory answer for the previous
    // strobe lands in the same cycle as the next edge, so bypass the prefetch
    // register while a read response is in flight.
    assign next_byte = rd_pend ? mem_rd_data_i : prefetch;

    assign busy_o = (state != ST_IDLE) && !ce_high;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            cmd_q           <= 8'h00;
            edge_cnt        <= 3'd0;
            addr_sr         <= 32'd0;
            lat_cnt         <= 8'd0;
            is_wr           <= 1'b0;
            ptr             <= '0;
            prefetch        <= 8'h00;
            rd_pend         <= 1'b0;
            psram_io_out_o  <= 8'h00;
            psram_io_en_o   <= 8'h00;
            psram_dqs_out_o <= 1'b0;
            psram_dqs_en_o  <= 1'b0;
            mem_addr_o      <= '0;
            mem_wr_en_o     <= 1'b0;
            mem_wr_data_o   <= 8'h00;
            mem_rd_en_o     <= 1'b0;
        end else begin
            // Memory strobes are single-cycle pulses.
            mem_wr_en_o <= 1'b0;
            mem_rd_en_o <= 1'b0;
            rd_pend     <= mem_rd_en_o;
            if (rd_pend)
                prefetch <= mem_rd_data_i;

            if (ce_high) begin
                // Deselect aborts from any state; an SCK edge in this same
                // cycle is dropped and no strobe is issued.
                state           <= ST_IDLE;
                edge_cnt        <= 3'd0;
                lat_cnt         <= 8'd0;
                rd_pend         <= 1'b0;
                psram_io_out_o  <= 8'h00;
                psram_io_en_o   <= 8'h00;
                psram_dqs_out_o <= 1'b0;
                psram_dqs_en_o  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ce_fall) begin
                            state    <= ST_CMD;
                            edge_cnt <= 3'd0;
                        end
                    end

                    ST_CMD: begin
                        if (sck_rise && edge_cnt == 3'd0) begin
                            cmd_q    <= io_q;
                            edge_cnt <= 3'd1;
                        end else if (sck_fall && edge_cnt == CMD_EDGES - 3'd1) begin
                            edge_cnt <= 3'd0;
                            if (cmd_q == RD_CMD) begin
                                is_wr <= 1'b0;
                                state <= ST_ADDR;
                            end else if (cmd_q == WR_CMD) begin
                                is_wr <= 1'b1;
                                state <= ST_ADDR;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (edge_evt) begin
                            addr_sr <= addr_full;
                            if (edge_cnt == ADDR_EDGES - 3'd1) begin
                                edge_cnt <= 3'd0;
                                ptr      <= addr_full[MEM_AW-1:0];
                                lat_cnt  <= is_wr ? cfg_wlc_i : cfg_rlc_i;
                                state    <= ST_LAT;
                                psram_dqs_out_o <= 1'b0;
                                if (!is_wr) begin
                                    // Fetch the first byte during the latency phase.
                                    mem_rd_en_o <= 1'b1;
                                    mem_addr_o  <= addr_full[MEM_AW-1:0];
                                end
                            end else begin
                                edge_cnt <= edge_cnt + 3'd1;
                            end
                        end
                    end

                    ST_LAT: begin
                        if (sck_rise) begin
                            if (lat_cnt == 8'd0) begin
                                if (is_wr) begin
                                    state <= ST_WDATA;
                                end else begin
                                    state          <= ST_RDATA;
                                    psram_io_en_o  <= 8'hFF;
                                    psram_dqs_en_o <= 1'b1;
                                end
                            end else begin
                                lat_cnt <= lat_cnt - 8'd1;
                            end
                        end
                    end

                    ST_WDATA, ST_RDATA, ST_IGNORE: begin
                        // Streaming is handled below; IGNORE waits for deselect.
                    end

                    default: state <= ST_IDLE;
                endcase

                if (data_edge) begin
                    ptr <= ptr_inc;
                    if (is_wr) begin
                        // Masked bytes still consume an address.
                        if (dqs_q) begin
                            mem_wr_en_o   <= 1'b1;
                            mem_addr_o    <= ptr;
                            mem_wr_data_o <= io_q;
                        end
                    end else begin
                        psram_io_out_o  <= next_byte;
                        psram_dqs_out_o <= ~psram_dqs_out_o;
                        mem_rd_en_o     <= 1'b1;
                        mem_addr_o      <= ptr_inc;
                    end
                end
            end
        end
    end

endmodule

// File: doc/psram_target.md
Name: psram_target

Overview:
- Synthesizable octal-DDR PSRAM responder: the device end of the link driven by the team's PSRAM controller.
- Oversamples SCK/CE/IO/DQS in its own clock domain. Decodes the command, the 32-bit address and the latency phase, then serves read/write bursts against a byte-wide memory port.
- Used as an on-chip memory target and as the bench-side device for controller regression.

Parameters:
- MEM_AW, 16, byte-address width of the memory port; address wraps at 2^MEM_AW.
- RD_CMD, 8'h00, read command code.
- WR_CMD, 8'h80, write command code.

Ports:
- clk_i  in  1  clock, at least 4x SCK.
- rst_i  in  1  synchronous reset, active-high.
- cfg_rlc_i  in  8  read latency in SCK cycles.
- cfg_wlc_i  in  8  write latency in SCK cycles.
- psram_sck_i  in  1  serial clock from controller.
- psram_ce_i  in  1  chip enable, active-low.
- psram_io_in_i  in  8  DQ from controller.
- psram_io_out_o  out  8  DQ to controller.
- psram_io_en_o  out  8  DQ output enable, 1 = drive.
- psram_dqs_in_i  in  1  write data mask, 1 = byte enabled.
- psram_dqs_out_o  out  1  read strobe.
- psram_dqs_en_o  out  1  DQS output enable.
- mem_addr_o  out  MEM_AW  byte address.
- mem_wr_en_o  out  1  one-cycle write strobe.
- mem_wr_data_o  out  8  write byte.
- mem_rd_en_o  out  1  one-cycle read strobe.
- mem_rd_data_i  in  8  read byte, valid the cycle after mem_rd_en_o.
- busy_o  out  1  1 while CE is low and state is not IDLE.

Behaviour:
- Sampling
  - All psram inputs are registered once.
  - A SCK edge event is registered-SCK differing from its previous value; rise and fall are distinguished.
  - DQ/DQS are taken from the same registered stage on the edge-event cycle.
- CE abort: registered CE high forces state IDLE in the next cycle from any state. Pending memory strobes are squashed; io_en and dqs_en drop to 0.
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, CMD, ADDR, LAT, WDATA, RDATA, IGNORE.
- IDLE -> CMD on the registered CE falling edge.
- CMD
  - Command byte is latched on the first SCK rise.
  - After the following fall, decode: RD_CMD -> ADDR(rd), WR_CMD -> ADDR(wr), other -> IGNORE.
- ADDR
  - Captures 4 bytes on 4 consecutive SCK edges (rise, fall, rise, fall), MSB first, into a 32-bit shift register.
  - After the 4th edge, the address pointer loads addr[MEM_AW-1:0] and the state goes to LAT with lat_cnt = rlc (read) or wlc (write).
- LAT
  - lat_cnt decrements on each SCK rise.
  - The data phase starts on the first SCK rise seen with lat_cnt == 0; that edge is data edge 0.
  - lc = 0 means data starts on the first rise after the address.
  - Read: on LAT entry assert mem_rd_en_o for the first byte (prefetch).
- WDATA
  - On every SCK edge, if the sampled DQS is 1: mem_wr_en_o = 1 for one cycle, with the current pointer and the sampled DQ.
  - The pointer increments on every edge, masked or not.
  - Unbounded burst until CE high.
- RDATA
  - io_en = 8'hFF and dqs_en = 1 from LAT exit until the abort.
  - On each SCK edge, in the same cycle: io_out = prefetched byte and dqs_out toggles. dqs_out starts at 0, so edge 0 gives a rise.
  - Also on each edge: pointer + 1 and mem_rd_en_o for the next byte. The byte is captured into the prefetch register on the following cycle.
  - Minimum 2 clk_i between SCK edges guarantees the prefetch is ready.
- IGNORE: no outputs driven; wait for CE high.
- Pointer wrap: 2^MEM_AW-1 + 1 -> 0.
- Simultaneous SCK edge and CE rise: the CE abort wins; that edge is discarded.
- Reset mid-burst: immediate IDLE, no memory strobe in that cycle.

Decomposition:
- psram_target_pkg holds:
  - state enum;
  - default command codes;
  - byte-count constants (CMD_EDGES = 2, ADDR_EDGES = 4).
- Sub-module psram_target_sampler:
  - input registers;
  - SCK rise/fall detect;
  - CE fall/rise detect.

Test Plan:
- Write, MEM_AW = 16, wlc = 2, cmd 8'h80, addr 32'h0000_0100, bytes A0..A7, DQS all 1 -> 8 mem writes to 0x100..0x107 with A0..A7.
- Write with DQS pattern 1,0,1,0,... -> writes only at 0x100, 0x102, 0x104, 0x106; the pointer still advances.
- Read, rlc = 3, addr 0x100 preloaded A0..A7 -> DQ A0..A7 on 8 successive SCK edges. DQS toggles 0->1->0...; io_en = FF only during RDATA.
- Read at 0xFFFE, 4 bytes -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Unknown cmd 8'h5A -> IGNORE; no mem strobes; io_en = 0 until CE high, then IDLE.
- CE rising after 3 read bytes, or rst_i mid-write -> IDLE next cycle; io_en/dqs_en = 0; no further mem strobes.
